cndm_micro_irq_mod: RTL and testbench

- Interrupt moderation stage placed directly downstream of the port's completion-write `irq` output.
- Counts completion events and coalesces them into interrupt requests. Releases a request when either an event-count threshold or a hold-off timer expires.
- Requests go out over a valid/ready handshake to the MSI/interrupt controller.
- After each delivered request the block is disarmed; the driver re-arms it explicitly, in the same manner as CQ arming.

---
 rtl/cndm_micro_irq_mod.sv | 108 ++++++++++
 tb/tb_cndm_micro_irq_mod.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/cndm_micro_irq_mod.sv
// Interrupt moderation: coalesces completion events into interrupt requests,
// released on an event-count threshold or a prescaled hold-off timer.
module cndm_micro_irq_mod #(
  parameter int CNT_W    = 16,
  parameter int TMR_W    = 16,
  parameter int PRESCALE = 250
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_en,
  input  logic [CNT_W-1:0] cfg_cnt_thresh,
  input  logic [TMR_W-1:0] cfg_timer,
  input  logic             arm,
  input  logic             event_in,
  output logic             irq_valid,
  input  logic             irq_ready,
  output logic             armed,
  output logic [CNT_W-1:0] pend_count
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic [1:0] {DISARMED, ARMED, COALESCE, FIRE} state_t;

  state_t           state, state_nxt;
  logic [PS_W-1:0]  ps_cnt;
  logic             tick;
  logic [TMR_W-1:0] timer, timer_nxt;
  logic [CNT_W-1:0] count, count_nxt, count_inc, thresh;
  logic             hs, hit;

  // Free-running prescaler; never restarted by state changes
  assign tick = (ps_cnt == PS_W'(PRESCALE - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       ps_cnt <= '0;
    else if (tick) ps_cnt <= '0;
    else           ps_cnt <= ps_cnt + 1'b1;
  end

  assign hs        = (state == FIRE) && irq_ready;
  assign count_inc = (&count) ? count : count + CNT_W'(event_in);
  assign thresh    = (cfg_cnt_thresh == '0) ? CNT_W'(1) : cfg_cnt_thresh;

  always_comb begin
    count_nxt = count_inc;
    if (!cfg_en)  count_nxt = '0;
    else if (hs)  count_nxt = CNT_W'(event_in);
  end

  // Evaluations see the count including this cycle's event
  assign hit = (count_nxt >= thresh);

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    case (state)
      DISARMED: begin
        if (cfg_en && arm) begin
          if (count_nxt == '0) state_nxt = ARMED;
          else if (hit)        state_nxt = FIRE;
          else begin
            state_nxt = COALESCE;
            timer_nxt = cfg_timer;
          end
        end
      end
      ARMED: begin
        if (!cfg_en) state_nxt = DISARMED;
        else if (event_in) begin
          if (hit) state_nxt = FIRE;
          else begin
            state_nxt = COALESCE;
            timer_nxt = cfg_timer;
          end
        end
      end
      COALESCE: begin
        if (tick && (timer != '0)) timer_nxt = timer - 1'b1;
        if (!cfg_en)                     state_nxt = DISARMED;
        else if (hit || (timer == '0))   state_nxt = FIRE;
      end
      FIRE: begin
        if (hs) state_nxt = DISARMED;
      end
      default: state_nxt = DISARMED;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= DISARMED;
      timer     <= '0;
      count     <= '0;
      irq_valid <= 1'b0;
      armed     <= 1'b0;
    end else begin
      state     <= state_nxt;
      timer     <= timer_nxt;
      count     <= count_nxt;
      irq_valid <= (state_nxt == FIRE);
      armed     <= (state_nxt != DISARMED);
    end
  end

  assign pend_count = count;

endmodule

// File: tb/tb_cndm_micro_irq_mod.sv
// Randomized + directed bench for the interrupt moderation stage; a per-edge
// reference model feeds a scoreboard queue drained by an independent monitor.
module tb_cndm_micro_irq_mod;

  localparam int CNT_W    = 4;
  localparam int TMR_W    = 8;
  localparam int PRESCALE = 4;
  localparam int MAXC     = (1 << CNT_W) - 1;

  logic             clk, rst;
  logic             cfg_en;
  logic [CNT_W-1:0] cfg_cnt_thresh;
  logic [TMR_W-1:0] cfg_timer;
  logic             arm, event_in, irq_valid, irq_ready, armed;
  logic [CNT_W-1:0] pend_count;

  cndm_micro_irq_mod #(.CNT_W(CNT_W), .TMR_W(TMR_W), .PRESCALE(PRESCALE)) dut (
    .clk(clk), .rst(rst), .cfg_en(cfg_en), .cfg_cnt_thresh(cfg_cnt_thresh),
    .cfg_timer(cfg_timer), .arm(arm), .event_in(event_in),
    .irq_valid(irq_valid), .irq_ready(irq_ready), .armed(armed),
    .pend_count(pend_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int v;
    int a;
    int p;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: pending events, whether the driver has armed us, whether
  // a request is outstanding, and a hold-off deadline in absolute tick counts.
  int m_cnt, m_dl, m_ticks, m_k;
  bit m_armed, m_fire, m_coal;

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp_v);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_dl = 0; m_ticks = 0; m_k = 0;
    m_armed = 0; m_fire = 0; m_coal = 0;
  endtask

  // Drive one cycle of inputs, predict outputs after the coming edge.
  task automatic step(input bit en, input int th, input int tm,
                      input bit a, input bit ev, input bit rdy);
    bit tick, hs;
    int thr, nc, t_after;
    exp_t e;
    cfg_en = en; cfg_cnt_thresh = CNT_W'(th); cfg_timer = TMR_W'(tm);
    arm = a; event_in = ev; irq_ready = rdy;

    tick    = (m_k % PRESCALE) == PRESCALE - 1;
    thr     = (th == 0) ? 1 : th;
    hs      = m_fire && rdy;
    t_after = m_ticks + int'(tick);
    if (!en)      nc = 0;
    else if (hs)  nc = int'(ev);
    else          nc = (m_cnt + int'(ev) > MAXC) ? MAXC : m_cnt + int'(ev);

    if (m_fire) begin
      if (hs) begin m_fire = 0; m_armed = 0; end
    end else if (!m_armed) begin
      if (en && a) begin
        m_armed = 1;
        if (nc >= thr) m_fire = 1;
        else if (nc > 0) begin m_coal = 1; m_dl = t_after + tm; end
      end
    end else if (!en) begin
      m_armed = 0; m_coal = 0;
    end else if (!m_coal) begin
      if (ev) begin
        if (nc >= thr) m_fire = 1;
        else begin m_coal = 1; m_dl = t_after + tm; end
      end
    end else if (nc >= thr || m_ticks >= m_dl) begin
      m_fire = 1; m_coal = 0;
    end
    m_cnt = nc; m_ticks = t_after; m_k++;

    e.v = int'(m_fire); e.a = int'(m_armed); e.p = m_cnt;
    q.push_back(e);
    @(posedge clk); #3;
  endtask

  task automatic idle(input int n, input int th, input int tm, input bit rdy);
    for (int i = 0; i < n; i++) step(1, th, tm, 0, 0, rdy);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_valid", int'(irq_valid), 0);
    chk("rst_armed", int'(armed), 0);
    chk("rst_pend", int'(pend_count), 0);
    cfg_en = 1'b1; arm = 1'b0; event_in = 1'b0; irq_ready = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    model_reset();
  endtask

  // Monitor: compares each edge's outputs against the queued prediction
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("irq_valid", int'(irq_valid), e.v);
        chk("armed", int'(armed), e.a);
        chk("pend_count", int'(pend_count), e.p);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cfg_en = 1'b1; cfg_cnt_thresh = '0; cfg_timer = '0;
    arm = 1'b0; event_in = 1'b0; irq_ready = 1'b0;
    model_reset();
    @(posedge clk); #3;
    do_reset();

    // Threshold reached by consecutive events
    step(1, 4, 200, 1, 0, 1);
    for (int i = 0; i < 4; i++) step(1, 4, 200, 0, 1, 1);
    idle(3, 4, 200, 1);

    // Hold-off timer expiry
    step(1, 15, 3, 1, 0, 1);
    step(1, 15, 3, 0, 1, 1);
    idle(20, 15, 3, 1);

    // Timer of zero: fires two cycles after the event
    step(1, 15, 0, 1, 0, 1);
    step(1, 15, 0, 0, 1, 1);
    idle(4, 15, 0, 1);

    // Accumulation while disarmed, then arm over threshold
    for (int i = 0; i < 5; i++) step(1, 4, 50, 0, 1, 1);
    idle(2, 4, 50, 1);
    step(1, 4, 50, 1, 0, 1);
    idle(3, 4, 50, 1);

    // Backpressure with events during FIRE, handshake with coincident event
    step(1, 1, 50, 1, 0, 0);
    step(1, 1, 50, 0, 1, 0);
    for (int i = 0; i < 10; i++) step(1, 1, 50, 0, (i % 3) == 1, 0);
    step(1, 1, 50, 0, 1, 1);
    idle(3, 1, 50, 1);

    // Saturation, then disable during COALESCE and during FIRE
    for (int i = 0; i < 20; i++) step(1, 15, 50, 0, 1, 1);
    step(0, 15, 50, 0, 0, 1);
    step(1, 15, 50, 1, 1, 1);
    idle(3, 15, 50, 1);
    step(0, 15, 50, 0, 0, 1);
    idle(3, 15, 50, 1);
    step(1, 1, 50, 1, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 50, 1, 0, 0);
    step(0, 1, 50, 0, 0, 1);
    idle(3, 1, 50, 1);

    // Async reset while a request is outstanding
    step(1, 1, 50, 1, 1, 0);
    idle(2, 1, 50, 0);
    do_reset();
    for (int i = 0; i < 6; i++) step(1, 1, 0, 0, i % 2, 1);
    step(1, 1, 0, 1, 0, 1);
    step(1, 1, 0, 0, 1, 1);
    idle(3, 1, 0, 1);

    // Randomized segments with live cfg changes
    for (int s = 0; s < 60; s++) begin
      int th, tm, evp, rdp;
      th  = $urandom_range(0, 6);
      tm  = $urandom_range(0, 5);
      evp = $urandom_range(1, 4);
      rdp = $urandom_range(0, 3);
      for (int i = 0; i < 40; i++) begin
        step(($urandom % 20) != 0, th, tm, ($urandom % 6) == 0,
             ($urandom % evp) == 0, ($urandom % 4) >= rdp);
        if (($urandom % 25) == 0) tm = $urandom_range(0, 5);
      end
    end

    repeat (2) @(posedge clk);
    #3;
    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
